r4_pingpong_stage_ram: RTL and testbench

//  Double-buffered (ping-pong) inter-stage RAM for the radix-4 pipeline FFT. The upstream

---
 rtl/r4_pingpong_stage_ram_if.sv | 32 +++
 rtl/r4_pingpong_stage_ram.sv | 125 ++++++++++++
 tb/tb_r4_pingpong_stage_ram.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/r4_pingpong_stage_ram_if.sv
// rtl/r4_pingpong_stage_ram_if.sv - write/read/error bus of the ping-pong stage RAM
// master: upstream/downstream stage side; slave: the RAM block.
interface r4_pingpong_stage_ram_if #(
  parameter int DATA_W = 36,
  parameter int ADDR_W = 7
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_last;
  logic              wr_bank_rdy;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_frame_rdy;
  logic              rd_done;
  logic              rd_par_err;
  logic              ovf_err;
  logic              udf_err;
  logic              clr_err;

  modport master (
    output wr_en, wr_addr, wr_data, wr_last, rd_en, rd_addr, rd_done, clr_err,
    input  wr_bank_rdy, rd_data, rd_valid, rd_frame_rdy, rd_par_err, ovf_err, udf_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_last, rd_en, rd_addr, rd_done, clr_err,
    output wr_bank_rdy, rd_data, rd_valid, rd_frame_rdy, rd_par_err, ovf_err, udf_err
  );
endinterface

// File: rtl/r4_pingpong_stage_ram.sv
// rtl/r4_pingpong_stage_ram.sv - double-buffered inter-stage RAM for the radix-4 FFT pipeline
// Optional stored even parity with read check: define PP_STAGE_RAM_PARITY_EN.
module r4_pingpong_stage_ram #(
  parameter int DATA_W = 36,
  parameter int ADDR_W = 7
) (
  input  logic                    clk_sys,
  input  logic                    rst_sys_n,
  r4_pingpong_stage_ram_if.slave  bus
);

`ifdef PP_STAGE_RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam int DEPTH = 2 ** ADDR_W;

  logic [MEM_W-1:0]  r_mem [2*DEPTH];
  logic [1:0]        r_full;
  logic              r_wr_sel;
  logic              r_rd_sel;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_ovf_err;
  logic              r_udf_err;

  logic              w_wr_bank_rdy;
  logic              w_rd_frame_rdy;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_ovf_evt;
  logic              w_udf_evt;
  logic              w_set_full;
  logic              w_clr_full;
  logic [1:0]        w_full_nxt;
  logic [MEM_W-1:0]  w_wr_word;
  logic [MEM_W-1:0]  w_rd_word;

  assign w_wr_bank_rdy  = ~r_full[r_wr_sel];
  assign w_rd_frame_rdy = r_full[r_rd_sel];

  assign w_wr_acc   = ~bus.wr_en & w_wr_bank_rdy;
  assign w_rd_acc   = ~bus.rd_en & w_rd_frame_rdy;
  assign w_ovf_evt  = ~bus.wr_en & ~w_wr_bank_rdy;
  assign w_udf_evt  = (~bus.rd_en | bus.rd_done) & ~w_rd_frame_rdy;
  // A dropped write never closes a frame, so wr_last only counts on accepted writes.
  assign w_set_full = w_wr_acc & bus.wr_last;
  assign w_clr_full = bus.rd_done & w_rd_frame_rdy;

`ifdef PP_STAGE_RAM_PARITY_EN
  assign w_wr_word = {^bus.wr_data, bus.wr_data};
`else
  assign w_wr_word = bus.wr_data;
`endif
  assign w_rd_word = r_mem[{r_rd_sel, bus.rd_addr}];

  // Write bank is free and read bank is full, so set and clear never hit the same bank.
  always_comb begin
    w_full_nxt = r_full;
    if (w_set_full) w_full_nxt[r_wr_sel] = 1'b1;
    if (w_clr_full) w_full_nxt[r_rd_sel] = 1'b0;
  end

  always_ff @(posedge clk_sys) begin
    if (w_wr_acc) r_mem[{r_wr_sel, bus.wr_addr}] <= w_wr_word;
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_full   <= 2'b00;
      r_wr_sel <= 1'b0;
      r_rd_sel <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      if (w_set_full) r_wr_sel <= ~r_wr_sel;
      if (w_clr_full) r_rd_sel <= ~r_rd_sel;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) r_rd_data <= w_rd_word[DATA_W-1:0];
    end
  end

  // A new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_ovf_err <= 1'b0;
      r_udf_err <= 1'b0;
    end else begin
      r_ovf_err <= w_ovf_evt | (r_ovf_err & ~bus.clr_err);
      r_udf_err <= w_udf_evt | (r_udf_err & ~bus.clr_err);
    end
  end

`ifdef PP_STAGE_RAM_PARITY_EN
  logic r_rd_par_err;

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_rd_par_err <= 1'b0;
    end else if (w_rd_acc) begin
      r_rd_par_err <= ^w_rd_word;
    end
  end

  assign bus.rd_par_err = r_rd_par_err;
`else
  assign bus.rd_par_err = 1'b0;
`endif

  assign bus.wr_bank_rdy  = w_wr_bank_rdy;
  assign bus.rd_frame_rdy = w_rd_frame_rdy;
  assign bus.rd_data      = r_rd_data;
  assign bus.rd_valid     = r_rd_valid;
  assign bus.ovf_err      = r_ovf_err;
  assign bus.udf_err      = r_udf_err;

endmodule

// File: tb/tb_r4_pingpong_stage_ram.sv
// tb/tb_r4_pingpong_stage_ram.sv - self-checking bench for r4_pingpong_stage_ram
// Directed frames plus random traffic against a bank-level reference model.
module tb_r4_pingpong_stage_ram;
  localparam int DATA_W = 36;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  r4_pingpong_stage_ram_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  r4_pingpong_stage_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_sys   (clk),
    .rst_sys_n (rst_n),
    .bus       (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: two banks of words, a "holds a complete frame" flag per bank,
  // and which bank the writer / reader currently owns.
  logic [DATA_W-1:0] m_mem  [2][DEPTH];
  bit                m_perr [2][DEPTH];
  bit                m_full [2];
  int                m_wbank, m_rbank;
  logic [DATA_W-1:0] m_rd_data;
  bit                m_rd_valid, m_par, m_ovf, m_udf;
  int                perm [DEPTH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_wr_bank_rdy"},  64'(bus.wr_bank_rdy),  64'(!m_full[m_wbank]));
    chk({tag, "_rd_frame_rdy"}, 64'(bus.rd_frame_rdy), 64'(m_full[m_rbank]));
    chk({tag, "_rd_valid"},     64'(bus.rd_valid),     64'(m_rd_valid));
    chk({tag, "_rd_data"},      64'(bus.rd_data),      64'(m_rd_data));
    chk({tag, "_rd_par_err"},   64'(bus.rd_par_err),   64'(m_par));
    chk({tag, "_ovf_err"},      64'(bus.ovf_err),      64'(m_ovf));
    chk({tag, "_udf_err"},      64'(bus.udf_err),      64'(m_udf));
  endtask

  task automatic model_reset();
    m_full[0] = 0; m_full[1] = 0;
    m_wbank = 0; m_rbank = 0;
    m_rd_data = '0; m_rd_valid = 0; m_par = 0; m_ovf = 0; m_udf = 0;
  endtask

  task automatic do_reset();
    bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.wr_last = 1'b0;
    bus.rd_done = 1'b0; bus.clr_err = 1'b0;
    bus.wr_addr = '0; bus.rd_addr = '0; bus.wr_data = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();
    #1 check_all("reset");
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare everything.
  task automatic step(input bit we_n, input int wa, input logic [DATA_W-1:0] wd, input bit wl,
                      input bit re_n, input int ra, input bit done, input bit clr, input string tag);
    bit wr_free, rd_full, new_ovf, new_udf;
    bus.wr_en = we_n; bus.wr_addr = ADDR_W'(wa); bus.wr_data = wd; bus.wr_last = wl;
    bus.rd_en = re_n; bus.rd_addr = ADDR_W'(ra); bus.rd_done = done; bus.clr_err = clr;
    @(posedge clk);
    #1;
    wr_free = !m_full[m_wbank];
    rd_full = m_full[m_rbank];
    new_ovf = 0; new_udf = 0;
    m_rd_valid = 0;
    if (!re_n) begin
      if (rd_full) begin
        m_rd_data  = m_mem[m_rbank][ra];
        m_par      = m_perr[m_rbank][ra];
        m_rd_valid = 1;
      end else new_udf = 1;
    end
    if (!we_n) begin
      if (wr_free) begin
        m_mem[m_wbank][wa]  = wd;
        m_perr[m_wbank][wa] = 0;
        if (wl) begin
          m_full[m_wbank] = 1;
          m_wbank = 1 - m_wbank;
        end
      end else new_ovf = 1;
    end
    if (done) begin
      if (rd_full) begin
        m_full[m_rbank] = 0;
        m_rbank = 1 - m_rbank;
      end else new_udf = 1;
    end
    if (clr) begin m_ovf = 0; m_udf = 0; end
    if (new_ovf) m_ovf = 1;
    if (new_udf) m_udf = 1;
    check_all(tag);
  endtask

  task automatic shuffle();
    for (int i = 0; i < DEPTH; i++) perm[i] = i;
    for (int i = DEPTH - 1; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(i, 0));
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < DEPTH; a++) begin m_mem[b][a] = '0; m_perr[b][a] = 0; end

    // 1: reset values
    do_reset();
    chk("t1_wr_bank_rdy", 64'(bus.wr_bank_rdy), 64'd1);
    chk("t1_rd_frame_rdy", 64'(bus.rd_frame_rdy), 64'd0);
    chk("t1_rd_data", 64'(bus.rd_data), 64'd0);
    chk("t1_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("t1_ovf_err", 64'(bus.ovf_err), 64'd0);
    chk("t1_udf_err", 64'(bus.udf_err), 64'd0);

    // 5: rd_done with no full bank, then clear
    step(1, 0, '0, 0, 1, 0, 1, 0, "t5_done");
    chk("t5_udf_set", 64'(bus.udf_err), 64'd1);
    chk("t5_rd_frame_rdy", 64'(bus.rd_frame_rdy), 64'd0);
    step(1, 0, '0, 0, 1, 0, 0, 1, "t5_clr");
    chk("t5_udf_clr", 64'(bus.udf_err), 64'd0);

    // 2: frame data=addr into bank0, read addr 5
    for (int a = 0; a < DEPTH; a++) step(0, a, DATA_W'(a), a == DEPTH - 1, 1, 0, 0, 0, "t2_wr");
    chk("t2_rd_frame_rdy", 64'(bus.rd_frame_rdy), 64'd1);
    chk("t2_wr_bank_rdy", 64'(bus.wr_bank_rdy), 64'd1);
    step(1, 0, '0, 0, 0, 5, 0, 0, "t2_rd");
    chk("t2_rd_data", 64'(bus.rd_data), 64'd5);
    chk("t2_rd_valid", 64'(bus.rd_valid), 64'd1);
    step(1, 0, '0, 0, 1, 0, 0, 0, "t2_idle");

    // 3: fill bank1 in random order, overflow write, bank0 untouched
    shuffle();
    for (int i = 0; i < DEPTH; i++)
      step(0, perm[i], DATA_W'({$urandom, $urandom}), i == DEPTH - 1, 1, 0, 0, 0, "t3_wr");
    chk("t3_wr_bank_rdy", 64'(bus.wr_bank_rdy), 64'd0);
    step(0, 0, DATA_W'('hABC), 0, 1, 0, 0, 0, "t3_ovf");
    chk("t3_ovf_err", 64'(bus.ovf_err), 64'd1);
    step(1, 0, '0, 0, 0, 0, 0, 0, "t3_rd0");
    chk("t3_rd_data0", 64'(bus.rd_data), 64'd0);

    // reset mid-traffic discards both frames
    do_reset();
    chk("rst_wr_bank_rdy", 64'(bus.wr_bank_rdy), 64'd1);
    chk("rst_rd_frame_rdy", 64'(bus.rd_frame_rdy), 64'd0);

    // 4: stream 4 frames, wr_last coinciding with rd_done
    shuffle();
    for (int i = 0; i < DEPTH; i++)
      step(0, perm[i], DATA_W'(perm[i]), i == DEPTH - 1, 1, 0, 0, 0, "t4_f0");
    for (int k = 1; k < 4; k++) begin
      int rp [DEPTH];
      shuffle();
      rp = perm;
      shuffle();
      for (int i = 0; i < DEPTH; i++) begin
        step(0, perm[i], DATA_W'(k * 256 + perm[i]), i == DEPTH - 1,
             0, rp[i], i == DEPTH - 1, 0, "t4_stream");
        chk("t4_frame_data", 64'(bus.rd_data), 64'((k - 1) * 256 + rp[i]));
      end
    end
    for (int a = 0; a < DEPTH; a++) begin
      step(1, 0, '0, 0, 0, a, a == DEPTH - 1, 0, "t4_tail");
      chk("t4_frame3_data", 64'(bus.rd_data), 64'(3 * 256 + a));
    end
    chk("t4_no_ovf", 64'(bus.ovf_err), 64'd0);
    chk("t4_no_udf", 64'(bus.udf_err), 64'd0);

    // random traffic: strobes, frame ends, releases and clears at random
    for (int n = 0; n < 1500; n++)
      step($urandom_range(3, 0) == 0, int'($urandom_range(DEPTH - 1, 0)),
           DATA_W'({$urandom, $urandom}), $urandom_range(30, 0) == 0,
           $urandom_range(2, 0) == 0, int'($urandom_range(DEPTH - 1, 0)),
           $urandom_range(30, 0) == 0, $urandom_range(20, 0) == 0, "rand");

`ifdef PP_STAGE_RAM_PARITY_EN
    // 6: corrupt the stored parity bit of bank0 addr 3
    do_reset();
    for (int a = 0; a < DEPTH; a++)
      step(0, a, DATA_W'({$urandom, $urandom}), a == DEPTH - 1, 1, 0, 0, 0, "t6_wr");
    dut.r_mem[3][DATA_W] = ~dut.r_mem[3][DATA_W];
    m_perr[0][3] = 1;
    step(1, 0, '0, 0, 0, 3, 0, 0, "t6_rd3");
    chk("t6_par_err3", 64'(bus.rd_par_err), 64'd1);
    chk("t6_valid3", 64'(bus.rd_valid), 64'd1);
    step(1, 0, '0, 0, 0, 4, 0, 0, "t6_rd4");
    chk("t6_par_err4", 64'(bus.rd_par_err), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
